// File: rtl/stft_bin_integrator.sv
// stft_bin_integrator
// Non-coherent integrator for STFT magnitude frames. Each of the NBIN bins
// in a frame is summed across NFRM consecutive frames in an internal bank.
// During the final frame of each group, every bin is emitted as a scaled,
// saturated value together with its bin index.
//
// Ports
//   iCLK   : clock, rising edge
//   iRSTn  : asynchronous active-low reset
//   iCLR   : synchronous restart (counters and oOVF to 0, sample dropped)
//   iEN    : sample valid, one sample per cycle
//   iDATA  : bin magnitude, bins 0..NBIN-1 in order within a frame
//   oEN    : integrated bin valid (one cycle per bin)
//   oDATA  : integrated bin value, >> SHIFT, saturated to OL bits
//   oBIN   : bin index of oDATA
//   oDONE  : last bin of an integrated frame (qualifies oEN)
//   oFRM   : frame index of the next sample to be accepted
//   oOVF   : sticky saturation flag
module stft_bin_integrator #(
    parameter int unsigned IL    = 10,
    parameter int unsigned OL    = 16,
    parameter int unsigned NBIN  = 16,
    parameter int unsigned NFRM  = 9,
    parameter int unsigned SHIFT = 0,
    localparam int unsigned BW   = (NBIN > 1) ? $clog2(NBIN) : 1,
    localparam int unsigned FW   = (NFRM > 1) ? $clog2(NFRM) : 1
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iEN,
    input  logic [IL-1:0] iDATA,
    output logic          oEN,
    output logic [OL-1:0] oDATA,
    output logic [BW-1:0] oBIN,
    output logic          oDONE,
    output logic [FW-1:0] oFRM,
    output logic          oOVF
);

    localparam logic [BW-1:0] BIN_LAST = BW'(NBIN - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(NFRM - 1);

    // Bank of per-bin partial sums; contents intentionally not reset.
    logic [OL-1:0] acc_q [NBIN];

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          en_q, en_d;
    logic [OL-1:0] data_q, data_d;
    logic [BW-1:0] bin_q, bin_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    logic [OL-1:0] acc_rd_c;
    logic [OL:0]   sum_c;
    logic [OL-1:0] result_c;
    logic          sat_c;
    logic          acc_we_c;

    // Read-modify-write datapath: frame 0 loads, later frames add and clamp.
    always_comb begin
        acc_rd_c = acc_q[bcnt_q];
        sum_c    = {1'b0, acc_rd_c} + (OL+1)'(iDATA);
        sat_c    = 1'b0;
        if (fcnt_q == '0) begin
            result_c = OL'(iDATA);
        end else if (sum_c[OL]) begin
            result_c = '1;
            sat_c    = 1'b1;
        end else begin
            result_c = sum_c[OL-1:0];
        end
    end

    // Next-state and output logic.
    always_comb begin
        bcnt_d   = bcnt_q;
        fcnt_d   = fcnt_q;
        en_d     = 1'b0;
        done_d   = 1'b0;
        data_d   = data_q;
        bin_d    = bin_q;
        ovf_d    = ovf_q;
        acc_we_c = 1'b0;

        if (iCLR) begin
            bcnt_d = '0;
            fcnt_d = '0;
            ovf_d  = 1'b0;
        end else if (iEN) begin
            acc_we_c = 1'b1;
            if (sat_c) begin
                ovf_d = 1'b1;
            end
            if (fcnt_q == FRM_LAST) begin
                en_d   = 1'b1;
                data_d = result_c >> SHIFT;
                bin_d  = bcnt_q;
                done_d = (bcnt_q == BIN_LAST);
            end
            if (bcnt_q == BIN_LAST) begin
                bcnt_d = '0;
                fcnt_d = (fcnt_q == FRM_LAST) ? '0 : fcnt_q + FW'(1);
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            bcnt_q <= '0;
            fcnt_q <= '0;
            en_q   <= 1'b0;
            data_q <= '0;
            bin_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            fcnt_q <= fcnt_d;
            en_q   <= en_d;
            data_q <= data_d;
            bin_q  <= bin_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    // Bank write; a flop array read combinationally, so a write is visible
    // to the very next access of the same bin (covers NBIN==1).
    always_ff @(posedge iCLK) begin
        if (acc_we_c) begin
            acc_q[bcnt_q] <= result_c;
        end
    end

    assign oEN   = en_q;
    assign oDATA = data_q;
    assign oBIN  = bin_q;
    assign oDONE = done_q;
    assign oFRM  = fcnt_q;
    assign oOVF  = ovf_q;

endmodule
